// File: rtl/steer_pkg.sv
// Shared types for the dual-rail steer feeder: FSM states and rail encodings.
package steer_pkg;

  typedef enum logic [1:0] {
    RESYNC = 2'd0,
    READY  = 2'd1,
    DATA   = 2'd2
  } state_t;

  localparam logic [1:0] RAIL_NULL = 2'b00;
  localparam logic [1:0] RAIL_0    = 2'b01;
  localparam logic [1:0] RAIL_1    = 2'b10;

  function automatic logic [1:0] rail(input logic b);
    return b ? RAIL_1 : RAIL_0;
  endfunction

endpackage

// File: rtl/steer_feed_d2_if.sv
// Producer handshake plus the dual-rail link to the asynchronous steer stage.
// Handshake: a word moves when in_valid & in_ready are both high at a rising clk edge;
// in_valid/in_data/in_sel must hold until then. acomp is asynchronous (four-phase).
interface steer_feed_d2_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_data;
  logic       in_sel;
  logic [1:0] A;
  logic [1:0] steerin;
  logic       acomp;

  modport master (output in_valid, in_data, in_sel, acomp,
                  input  in_ready, A, steerin);
  modport slave  (input  in_valid, in_data, in_sel, acomp,
                  output in_ready, A, steerin);
endinterface

// File: rtl/steer_fifo.sv
// Small synchronous FIFO; push is ignored when full even if a pop happens that cycle.
module steer_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/steer_feed_d2.sv
// Clocked feeder for a dual-rail steer stage: FIFO -> DATA/NULL wavefronts,
// completion taken from a synchronized acomp. A and steerin come straight from flops.
module steer_feed_d2
  import steer_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   init_n,
  steer_feed_d2_if.slave         bus,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       xfer_cnt,
  output logic                   proto_err,
  output state_t                 state_dbg
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;
  logic                   rdy_en;
  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;
  logic [1:0]             head;
  state_t                 state;
  logic [1:0]             word_q;
  logic                   load_q;
  logic [1:0]             a_q;
  logic [1:0]             st_q;
  logic [CNT_W-1:0]       xfer_q;
  logic                   err_q;

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.acomp};
  end
  assign ack_s = sync_q[SYNC_STAGES-1];

  // Holds in_ready low through reset and releases it on the first clock after.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) rdy_en <= 1'b0;
    else         rdy_en <= 1'b1;
  end

  assign bus.in_ready = rdy_en && !full;
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = (state == READY) && !ack_s && !empty;

  steer_fifo #(.DEPTH(DEPTH), .W(2)) u_fifo (
    .clk   (clk),
    .rst_n (init_n),
    .push  (push),
    .pop   (pop),
    .wdata ({bus.in_data, bus.in_sel}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Entering DATA pops the word; load_q marks the one cycle spent still driving
  // NULL while the popped word is loaded into the rail flops.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state  <= RESYNC;
      word_q <= '0;
      load_q <= 1'b0;
      a_q    <= RAIL_NULL;
      st_q   <= RAIL_NULL;
      xfer_q <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        RESYNC: if (!ack_s) state <= READY;
        READY: begin
          if (ack_s) begin
            err_q <= 1'b1;
            state <= RESYNC;
          end else if (!empty) begin
            word_q <= head;
            load_q <= 1'b1;
            state  <= DATA;
          end
        end
        DATA: begin
          if (load_q) begin
            load_q <= 1'b0;
            if (ack_s) begin
              err_q <= 1'b1;
              state <= RESYNC;
            end else begin
              a_q  <= rail(word_q[1]);
              st_q <= rail(word_q[0]);
            end
          end else if (ack_s) begin
            a_q    <= RAIL_NULL;
            st_q   <= RAIL_NULL;
            xfer_q <= xfer_q + 1'b1;
            state  <= RESYNC;
          end
        end
        default: state <= RESYNC;
      endcase
    end
  end

  assign bus.A       = a_q;
  assign bus.steerin = st_q;
  assign xfer_cnt    = xfer_q;
  assign proto_err   = err_q;
  assign state_dbg   = state;

endmodule

// File: doc/steer_feed_d2.md
STEER_FEED_D2 -- requirements
Module: steer_feed_d2

Interface
REQ-001 Parameter: DEPTH, 4, entries in the input FIFO (power of 2, >=2).
REQ-002 Parameter: SYNC_STAGES, 2, flops in the acknowledge synchronizer (>=2).
REQ-003 Parameter: CNT_W, 16, width of the transfer counter.
REQ-004 Port: clk  input  1  single clock; all state is clocked on its rising edge.
REQ-005 Port: init_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port: in_valid  input  1  producer offers a word.
REQ-007 Port: in_ready  output  1  FIFO can accept; push occurs when in_valid & in_ready.
REQ-008 Port: in_data  input  1  data bit to be sent on A.
REQ-009 Port: in_sel  input  1  route select: 0 = S path, 1 = T path.
REQ-010 Port: A  output  2  dual-rail data to the steer stage: 00 NULL, 01 DATA0, 10 DATA1.
REQ-011 Port: steerin  output  2  one-hot steer control: 00 NULL, 01 S, 10 T.
REQ-012 Port: acomp  input  1  asynchronous completion from the steer stage (high = DATA received, low = NULL received).
REQ-013 Port: level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-014 Port: xfer_cnt  output  CNT_W  count of completed DATA wavefronts.
REQ-015 Port: proto_err  output  1  sticky protocol-violation flag.

Function
REQ-016 The block SHALL drive A and steerin directly from flops, with no combinational logic after the flops.
REQ-017 acomp SHALL pass through SYNC_STAGES flops; the synchronized value is ack_s.
REQ-018 The FSM SHALL have three states:
- RESYNC: NULL driven, waiting for ack_s=0.
- READY: NULL driven, ack_s low.
- DATA: DATA driven, waiting for ack_s=1.
REQ-019 RESYNC -> READY when ack_s=0; otherwise the FSM stays in RESYNC.
REQ-020 READY -> DATA when the FIFO is non-empty.
- Pop the head word.
- On the next edge, load A = in_data?10:01 and steerin = in_sel?10:01.
REQ-021 READY with ack_s=1 SHALL set proto_err and go to RESYNC, driving NULL. This check has priority over REQ-020.
REQ-022 DATA -> RESYNC when ack_s=1.
- Load A=00 and steerin=00 on that edge.
- Increment xfer_cnt.
REQ-023 In DATA, A and steerin SHALL hold stable until ack_s=1.
REQ-024 A and steerin SHALL never both hold DATA values in consecutive cycles; every DATA wavefront is separated by NULL.
REQ-025 FIFO ordering SHALL be first-in first-out; in_ready = !full.
REQ-026 Push and pop in the same cycle SHALL be legal when the FIFO is non-empty and not full; level is then unchanged.
REQ-027 When full, in_ready=0 and no push occurs, even if a pop happens the same cycle.
REQ-028 xfer_cnt SHALL wrap modulo 2^CNT_W.
REQ-029 proto_err SHALL stay set until reset.
REQ-030 Latency: FIFO empty, state READY, push at edge N -> DATA on A/steerin after edge N+2.

Reset
REQ-031 While init_n=0, the block SHALL immediately drive:
- A=00, steerin=00
- FIFO flushed, level=0, in_ready=0
- xfer_cnt=0, proto_err=0
- synchronizer flops=0
- state RESYNC
REQ-032 On the first edge after reset release, in_ready SHALL be 1.
REQ-033 A reset during DATA SHALL force NULL asynchronously and discard the in-flight word without counting it.
REQ-034 If ack_s=1 after reset, the FSM SHALL wait in RESYNC without flagging proto_err.

Structure
REQ-035 A shared package steer_pkg SHALL hold:
- the FSM state enum (RESYNC/READY/DATA)
- rail constants RAIL_NULL=2'b00, RAIL_0=2'b01, RAIL_1=2'b10
REQ-036 The FIFO SHALL be a separate sub-module steer_fifo (DEPTH, width 2), instantiated once.
REQ-037 The synchronizer SHALL be inline.

Verification
REQ-038 Reset, acomp=0; push {data=1, sel=0} -> A=10, steerin=01 after 2 edges; hold until acomp=1; NULL driven; xfer_cnt=1.
REQ-039 Push 4 words with the bench holding acomp: in_ready=0 at level=4. Release acomp four-phase: words emerge in order, xfer_cnt=4.
REQ-040 Raise acomp while in READY -> proto_err=1 and state RESYNC; proto_err remains after further traffic.
REQ-041 Assert init_n=0 mid-DATA -> A=00 and steerin=00 immediately; after release, level=0 and xfer_cnt=0.
REQ-042 Preload xfer_cnt path with 65535 transfers (CNT_W=16) -> the next completion gives xfer_cnt=0.
REQ-043 Random in_valid with a random-delay acomp responder -> no DATA-to-DATA adjacency, and the output sequence equals the input sequence.
